// File: rtl/scan_mux.sv
// N:1 mux with a registered output and a built-in channel scanner.
// A manual mode selects a channel directly; a scan mode steps a pointer through 0..min(last_ch,N-1).
module scan_mux #(
  parameter int W  = 1,
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel_in,
  input  logic [SW-1:0]   last_ch,
  input  logic [N*W-1:0]  I,
  output logic [W-1:0]    Y,
  output logic [SW-1:0]   y_ch,
  output logic            y_valid,
  output logic            sel_err,
  output logic            wrap
);

  // One extra bit so range checks stay meaningful when N is a power of two
  localparam logic [SW:0] NCH   = (SW+1)'(N);
  localparam logic [SW:0] MAXCH = (SW+1)'(N-1);

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ych_q, ych_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          wrap_q, wrap_d;

  logic [SW-1:0] lim, idx;
  logic          in_range;
  logic [W-1:0]  sel_data;

  always_comb begin
    lim = ({1'b0, last_ch} > MAXCH) ? MAXCH[SW-1:0] : last_ch;
    idx = mode ? ptr_q : sel_in;
    in_range = ({1'b0, idx} < NCH);
  end

  // Decoded AND-OR selection; an out-of-range index matches no channel and yields 0
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if ({1'b0, idx} == (SW+1)'(k)) sel_data = I[k*W +: W];
    end
  end

  always_comb begin
    y_d    = y_q;
    ych_d  = ych_q;
    ptr_d  = ptr_q;
    vld_d  = 1'b0;
    err_d  = 1'b0;
    wrap_d = 1'b0;
    if (en) begin
      y_d   = in_range ? sel_data : '0;
      ych_d = idx;
      vld_d = in_range;
      err_d = ~in_range;
      if (mode) begin
        // >= rather than == so a last_ch lowered below ptr still wraps at once
        wrap_d = (ptr_q >= lim);
        ptr_d  = wrap_d ? '0 : ptr_q + SW'(1);
      end else begin
        ptr_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      ych_q  <= '0;
      ptr_q  <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      ych_q  <= ych_d;
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
      wrap_q <= wrap_d;
    end
  end

  assign Y       = y_q;
  assign y_ch    = ych_q;
  assign y_valid = vld_q;
  assign sel_err = err_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: an N=8 and an N=6 instance share control inputs and are
// compared against a channel-level reference model after every edge.
module tb_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel_in = '0;
  logic [2:0] last_ch = '0;
  logic [7:0] i8 = '0;
  logic [5:0] i6;
  assign i6 = i8[5:0];

  logic [0:0] y8, y6;
  logic [2:0] ych8, ych6;
  logic       v8, v6, e8, e6, w8, w6;

  int nvec = 0;
  int nerr = 0;

  // expected state, index 0 = N=8 instance, index 1 = N=6 instance
  int m_ptr[2], m_y[2], m_ych[2], m_v[2], m_e[2], m_w[2];

  scan_mux #(.W(1), .N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .last_ch(last_ch),
    .I(i8), .Y(y8), .y_ch(ych8), .y_valid(v8), .sel_err(e8), .wrap(w8));

  scan_mux #(.W(1), .N(6)) u6 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .last_ch(last_ch),
    .I(i6), .Y(y6), .y_ch(ych6), .y_valid(v6), .sel_err(e6), .wrap(w6));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_y[d] = 0; m_ych[d] = 0; m_v[d] = 0; m_e[d] = 0; m_w[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int n;
      int lim;
      logic [7:0] data;
      n    = (d == 0) ? 8 : 6;
      data = (d == 0) ? i8 : {2'b00, i6};
      lim  = (int'(last_ch) < n) ? int'(last_ch) : n - 1;
      if (!en) begin
        m_v[d] = 0; m_e[d] = 0; m_w[d] = 0;
      end else if (!mode) begin
        m_ych[d] = sel_in;
        if (int'(sel_in) < n) begin
          m_y[d] = data[sel_in]; m_v[d] = 1; m_e[d] = 0;
        end else begin
          m_y[d] = 0; m_v[d] = 0; m_e[d] = 1;
        end
        m_ptr[d] = 0; m_w[d] = 0;
      end else begin
        m_y[d] = data[m_ptr[d]]; m_ych[d] = m_ptr[d]; m_v[d] = 1; m_e[d] = 0;
        m_w[d] = (m_ptr[d] >= lim) ? 1 : 0;
        m_ptr[d] = m_w[d] ? 0 : m_ptr[d] + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("y8", 32'(y8), m_y[0]);       chk("y6", 32'(y6), m_y[1]);
    chk("ych8", 32'(ych8), m_ych[0]); chk("ych6", 32'(ych6), m_ych[1]);
    chk("vld8", 32'(v8), m_v[0]);     chk("vld6", 32'(v6), m_v[1]);
    chk("err8", 32'(e8), m_e[0]);     chk("err6", 32'(e6), m_e[1]);
    chk("wrap8", 32'(w8), m_w[0]);    chk("wrap6", 32'(w6), m_w[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // reset pulse placed between edges; outputs must clear with no clock
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all();
    #1 rst_n = 1'b1;

    // manual sampling
    en = 1; mode = 0; sel_in = 6; i8 = 8'd64;
    step(); chk("man6_y", 32'(y8), 1); chk("man6_ch", 32'(ych8), 6); chk("man6_err6", 32'(e6), 1);
    sel_in = 3; i8 = 8'd8;   step(); chk("man3_y", 32'(y8), 1);
    sel_in = 7; i8 = 8'd128; step(); chk("man7_y", 32'(y8), 1);
    sel_in = 7; i8 = 8'd127; step(); chk("man7_y0", 32'(y8), 0); chk("man7_y6", 32'(y6), 0);
    i8 = 8'hFF; #2 check_all();  // input change between edges must not reach Y

    // scan with wrap at last_ch=3
    mode = 1; last_ch = 3; i8 = 8'b0000_1010;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("scan_ch", 32'(ych8), k % 4);
      chk("scan_wrap", 32'(w8), (k % 4 == 3) ? 1 : 0);
    end

    // pause, then lower last_ch below the frozen pointer
    mode = 0; step();
    mode = 1; step(); step(); chk("pause_pre", 32'(ych8), 1);
    en = 0; repeat (3) step(); chk("pause_vld", 32'(v8), 0); chk("pause_hold", 32'(ych8), 1);
    last_ch = 1; en = 1;
    step(); chk("lower_ch", 32'(ych8), 2); chk("lower_wrap", 32'(w8), 1);
    step(); chk("lower_next", 32'(ych8), 0);

    // clamp: last_ch=7 on N=6 wraps at 5
    last_ch = 7; mode = 0; step();
    mode = 1;
    for (int k = 0; k < 12; k++) begin
      step(); chk("clamp_ch6", 32'(ych6), k % 6); chk("clamp_wrap6", 32'(w6), (k % 6 == 5) ? 1 : 0);
    end

    // mode switching and reset mid-scan
    mode = 0; step(); mode = 1;
    repeat (5) step(); chk("sw_ch4", 32'(ych8), 4);
    mode = 0; sel_in = 2; step(); chk("sw_man", 32'(ych8), 2);
    mode = 1; step(); chk("sw_scan0", 32'(ych8), 0);
    step(); step();
    do_reset();
    step(); chk("rst_ch0", 32'(ych8), 0);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      i8 = 8'($urandom);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel_in = 3'($urandom);
      if ($urandom_range(0, 5) == 0) last_ch = 3'($urandom);
      if ($urandom_range(0, 49) == 0) do_reset();
      step();
      i8 = 8'($urandom);
      #1 check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
